// File: rtl/beam_topk_select.sv
// Per-RBG top-K beam selector.
// Scans one beam per cycle through a streaming insertion sort and reports the
// TOPK strongest beams (index + magnitude), strongest first. One vector can
// wait in a pending register while another is being scanned.
module beam_topk_select #(
    parameter int BEAM = 16,
    parameter int OW   = 48,
    parameter int TOPK = 4,
    parameter int RBGW = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [BEAM*OW-1:0]             i_rbg_abs,
    input  logic [RBGW-1:0]                i_rbg_idx,
    input  logic                           i_rbg_vld,
    output logic [TOPK*$clog2(BEAM)-1:0]   o_beam_idx,
    output logic [TOPK*OW-1:0]             o_beam_pwr,
    output logic [RBGW-1:0]                o_rbg_idx,
    output logic                           o_tvalid,
    output logic                           o_busy,
    output logic                           o_drop
);

    localparam int IW = $clog2(BEAM);

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic [OW-1:0] pwr;
    } entry_t;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_q, state_d;
    logic [BEAM*OW-1:0]     work_abs, pend_abs;
    logic [RBGW-1:0]        work_idx, pend_idx;
    logic                   pend_vld;
    logic [IW-1:0]          cnt;
    entry_t [TOPK-1:0]      lst, nxt;
    logic [TOPK-1:0]        ins;
    logic [OW-1:0]          v;
    logic                   last;
    logic                   start_in, start_pend, pend_set, pend_clr, drop_d, done;

    assign v      = work_abs[cnt*OW +: OW];
    assign last   = (cnt == IW'(BEAM-1));
    assign o_busy = (state_q == SCAN) | pend_vld;

    // Insertion of the current beam into the sorted list. The list is sorted
    // with valid entries first, so ins[] is a thermometer: the first set bit
    // is the insert slot, every set bit above it takes its upper neighbour.
    always_comb begin
        ins = '0;
        nxt = lst;
        for (int k = 0; k < TOPK; k++)
            ins[k] = !lst[k].vld || (v > lst[k].pwr);
        if (ins[0])
            nxt[0] = {1'b1, cnt, v};
        for (int k = 1; k < TOPK; k++)
            if (ins[k])
                nxt[k] = ins[k-1] ? lst[k-1] : {1'b1, cnt, v};
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state plus load/accept/drop decisions for the datapath.
    always_comb begin
        state_d    = state_q;
        start_in   = 1'b0;
        start_pend = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        drop_d     = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rbg_vld) begin
                    state_d  = SCAN;
                    start_in = 1'b1;
                end
            end
            SCAN: begin
                if (last) begin
                    done = 1'b1;
                    if (pend_vld) begin
                        // pending wins; a same-cycle input refills pending
                        start_pend = 1'b1;
                        if (i_rbg_vld) pend_set = 1'b1;
                        else           pend_clr = 1'b1;
                    end else if (i_rbg_vld) begin
                        start_in = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (i_rbg_vld) begin
                    if (pend_vld) drop_d   = 1'b1;
                    else          pend_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, sorted list and result registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_vld   <= 1'b0;
            cnt        <= '0;
            lst        <= '0;
            o_beam_idx <= '0;
            o_beam_pwr <= '0;
            o_rbg_idx  <= '0;
            o_tvalid   <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_tvalid <= done;
            o_drop   <= drop_d;
            if (done) begin
                for (int k = 0; k < TOPK; k++) begin
                    o_beam_idx[k*IW +: IW] <= nxt[k].idx;
                    o_beam_pwr[k*OW +: OW] <= nxt[k].pwr;
                end
                o_rbg_idx <= work_idx;
            end
            if (start_in || start_pend) begin
                lst <= '0;
                cnt <= '0;
            end else if (state_q == SCAN) begin
                lst <= nxt;
                cnt <= cnt + 1'b1;
            end
            if (pend_set)      pend_vld <= 1'b1;
            else if (pend_clr) pend_vld <= 1'b0;
        end
    end

    // Vector payload registers; qualified by the control flags above.
    always_ff @(posedge i_clk) begin
        if (start_in) begin
            work_abs <= i_rbg_abs;
            work_idx <= i_rbg_idx;
        end else if (start_pend) begin
            work_abs <= pend_abs;
            work_idx <= pend_idx;
        end
        if (pend_set) begin
            pend_abs <= i_rbg_abs;
            pend_idx <= i_rbg_idx;
        end
    end

endmodule
